// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central stall/flush scheduler for the 5-stage pipeline.
// Resolves hazard sources by fixed priority, sequences the multi-cycle
// divider in EX, and remembers a stale in-flight fetch after an exception.
module pipe_ctrl (
   input  logic clk,
   input  logic rst,
   input  logic i_stall,
   input  logic d_stall,
   input  logic load_use_hazardD,
   input  logic div_reqE,
   input  logic div_readyE,
   input  logic mispredictM,
   input  logic exceptM,
   output logic stallF,
   output logic stallD,
   output logic stallE,
   output logic stallM,
   output logic stallW,
   output logic flushD,
   output logic flushE,
   output logic flushM,
   output logic flushW,
   output logic div_start,
   output logic div_abort,
   output logic fetch_discard
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      DIV_RUN  = 2'd1,
      DIV_DONE = 2'd2
   } state_t;

   state_t state_q;
   logic   fd_q;

   logic exc_fire, gstall, div_stall, fd_clr;

   // Exceptions commit only once the M-stage data access has finished.
   assign exc_fire  = exceptM & ~d_stall;
   assign gstall    = i_stall | d_stall;
   assign div_stall = ((state_q == IDLE) & div_reqE) |
                      ((state_q == DIV_RUN) & ~div_readyE);
   // The stale fetch lands in IF/ID the cycle the fetch bus frees up.
   assign fd_clr    = fd_q & ~i_stall;

   // Launch only when nothing of higher priority owns the pipeline this cycle.
   assign div_start = ~rst & (state_q == IDLE) & div_reqE &
                      ~exc_fire & ~gstall & ~mispredictM;
   assign div_abort = ~rst & exc_fire & (state_q == DIV_RUN);
   assign fetch_discard = ~rst & (fd_q | (exc_fire & i_stall));

   // Priority-resolved stall/flush vector; flushes always override stalls.
   always_comb begin
      stallF = 1'b0; stallD = 1'b0; stallE = 1'b0; stallM = 1'b0; stallW = 1'b0;
      flushD = 1'b0; flushE = 1'b0; flushM = 1'b0; flushW = 1'b0;
      if (!rst) begin
         if (exc_fire) begin
            flushD = 1'b1; flushE = 1'b1; flushM = 1'b1; flushW = 1'b1;
         end else if (gstall) begin
            stallF = 1'b1; stallD = 1'b1; stallE = 1'b1; stallM = 1'b1; stallW = 1'b1;
         end else if (mispredictM) begin
            flushD = 1'b1;
            if (div_stall) begin
               stallE = 1'b1;
               flushM = 1'b1;
            end
         end else if (div_stall) begin
            stallF = 1'b1; stallD = 1'b1; stallE = 1'b1;
            flushM = 1'b1;
         end else if (load_use_hazardD) begin
            stallF = 1'b1; stallD = 1'b1;
            flushE = 1'b1;
         end
         if (fd_clr) flushD = 1'b1;
         stallD = stallD & ~flushD;
         stallE = stallE & ~flushE;
         stallM = stallM & ~flushM;
         stallW = stallW & ~flushW;
      end
   end

   // Divider sequencer and stale-fetch flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         fd_q    <= 1'b0;
      end else begin
         if (exc_fire) begin
            state_q <= IDLE;
         end else begin
            case (state_q)
               IDLE:     if (div_start) state_q <= DIV_RUN;
               DIV_RUN:  if (div_readyE) state_q <= gstall ? DIV_DONE : IDLE;
               DIV_DONE: if (!stallE) state_q <= IDLE;
               default:  state_q <= IDLE;
            endcase
         end
         if (exc_fire && i_stall) fd_q <= 1'b1;
         else if (fd_clr)         fd_q <= 1'b0;
      end
   end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl. Outputs are packed as
// {stallF,stallD,stallE,stallM,stallW, flushD,flushE,flushM,flushW, div_start,div_abort,fetch_discard}.
module tb_pipe_ctrl;
   logic clk, rst;
   logic i_stall, d_stall, load_use_hazardD, div_reqE, div_readyE, mispredictM, exceptM;
   logic stallF, stallD, stallE, stallM, stallW;
   logic flushD, flushE, flushM, flushW;
   logic div_start, div_abort, fetch_discard;
   logic [11:0] outv, exp;
   int checks = 0;
   int errors = 0;

   assign outv = {stallF, stallD, stallE, stallM, stallW,
                  flushD, flushE, flushM, flushW, div_start, div_abort, fetch_discard};

   pipe_ctrl dut (
      .clk(clk), .rst(rst), .i_stall(i_stall), .d_stall(d_stall),
      .load_use_hazardD(load_use_hazardD), .div_reqE(div_reqE), .div_readyE(div_readyE),
      .mispredictM(mispredictM), .exceptM(exceptM),
      .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM), .stallW(stallW),
      .flushD(flushD), .flushE(flushE), .flushM(flushM), .flushW(flushW),
      .div_start(div_start), .div_abort(div_abort), .fetch_discard(fetch_discard)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic clr();
      i_stall = 0; d_stall = 0; load_use_hazardD = 0; div_reqE = 0;
      div_readyE = 0; mispredictM = 0; exceptM = 0;
   endtask

   task automatic test_reset();
      rst = 1; load_use_hazardD = 1; div_reqE = 1; exceptM = 1; i_stall = 1; #1;
      exp = 12'b0; checks++;
      if (outv !== exp) begin errors++; $display("FAIL rst_out: got %b exp %b", outv, exp); end
      tick();
      checks++;
      if (outv !== exp) begin errors++; $display("FAIL rst_out2: got %b exp %b", outv, exp); end
      rst = 0; clr(); #1;
      checks++;
      if (dut.state_q !== 2'd0) begin errors++; $display("FAIL rst_state: got %0d exp 0", dut.state_q); end
      checks++;
      if (outv !== exp) begin errors++; $display("FAIL rst_fd: got %b exp %b", outv, exp); end
   endtask

   task automatic test_load_use();
      load_use_hazardD = 1; #1;
      exp = {5'b11000, 4'b0100, 3'b000}; checks++;
      if (outv !== exp) begin errors++; $display("FAIL lu_c0: got %b exp %b", outv, exp); end
      tick(); load_use_hazardD = 0; #1;
      exp = 12'b0; checks++;
      if (outv !== exp) begin errors++; $display("FAIL lu_c1: got %b exp %b", outv, exp); end
      tick();
   endtask

   task automatic test_div_latency4();
      div_reqE = 1; #1;
      exp = {5'b11100, 4'b0010, 3'b100}; checks++;
      if (outv !== exp) begin errors++; $display("FAIL div_c0: got %b exp %b", outv, exp); end
      for (int c = 1; c <= 3; c++) begin
         tick();
         exp = {5'b11100, 4'b0010, 3'b000}; checks++;
         if (outv !== exp) begin errors++; $display("FAIL div_c%0d: got %b exp %b", c, outv, exp); end
      end
      tick(); div_readyE = 1; #1;
      exp = 12'b0; checks++;
      if (outv !== exp) begin errors++; $display("FAIL div_c4: got %b exp %b", outv, exp); end
      tick(); div_reqE = 0; #1;
      checks++;
      if (outv !== exp) begin errors++; $display("FAIL div_c5: got %b exp %b", outv, exp); end
      checks++;
      if (dut.state_q !== 2'd0) begin errors++; $display("FAIL div_idle: got %0d exp 0", dut.state_q); end
      clr(); tick();
   endtask

   task automatic test_div_dstall();
      div_reqE = 1; #1;
      exp = {5'b11100, 4'b0010, 3'b100}; checks++;
      if (outv !== exp) begin errors++; $display("FAIL divd_start: got %b exp %b", outv, exp); end
      tick(); tick();
      div_readyE = 1; d_stall = 1; #1;
      exp = {5'b11111, 4'b0000, 3'b000}; checks++;
      if (outv !== exp) begin errors++; $display("FAIL divd_c2: got %b exp %b", outv, exp); end
      for (int c = 3; c <= 4; c++) begin
         tick();
         checks++;
         if (dut.state_q !== 2'd2) begin errors++; $display("FAIL divd_state_c%0d: got %0d exp 2", c, dut.state_q); end
         checks++;
         if (outv !== exp) begin errors++; $display("FAIL divd_c%0d: got %b exp %b", c, outv, exp); end
      end
      tick(); d_stall = 0; #1;
      exp = 12'b0; checks++;
      if (outv !== exp) begin errors++; $display("FAIL divd_release: got %b exp %b", outv, exp); end
      tick(); div_reqE = 0; #1;
      checks++;
      if (dut.state_q !== 2'd0) begin errors++; $display("FAIL divd_idle: got %0d exp 0", dut.state_q); end
      clr(); tick();
   endtask

   task automatic test_exc_div();
      // plain exception during a divide
      div_reqE = 1; tick(); tick();
      exceptM = 1; #1;
      exp = {5'b00000, 4'b1111, 3'b010}; checks++;
      if (outv !== exp) begin errors++; $display("FAIL excdiv_abort: got %b exp %b", outv, exp); end
      tick(); clr(); #1;
      checks++;
      if (dut.state_q !== 2'd0) begin errors++; $display("FAIL excdiv_idle: got %0d exp 0", dut.state_q); end
      exp = 12'b0; checks++;
      if (outv !== exp) begin errors++; $display("FAIL excdiv_after: got %b exp %b", outv, exp); end
      tick();
      // exception coinciding with divider completion: exception wins
      div_reqE = 1; tick(); tick();
      exceptM = 1; div_readyE = 1; #1;
      exp = {5'b00000, 4'b1111, 3'b010}; checks++;
      if (outv !== exp) begin errors++; $display("FAIL excrdy_abort: got %b exp %b", outv, exp); end
      tick(); clr(); #1;
      checks++;
      if (dut.state_q !== 2'd0) begin errors++; $display("FAIL excrdy_idle: got %0d exp 0", dut.state_q); end
      tick();
   endtask

   task automatic test_exc_stall();
      exceptM = 1; d_stall = 1; i_stall = 1; #1;
      exp = {5'b11111, 4'b0000, 3'b000};
      for (int c = 0; c < 2; c++) begin
         checks++;
         if (outv !== exp) begin errors++; $display("FAIL excst_hold_c%0d: got %b exp %b", c, outv, exp); end
         tick();
      end
      d_stall = 0; #1;
      exp = {5'b00000, 4'b1111, 3'b001}; checks++;
      if (outv !== exp) begin errors++; $display("FAIL excst_fire: got %b exp %b", outv, exp); end
      tick(); exceptM = 0; #1;
      exp = {5'b11111, 4'b0000, 3'b001};
      for (int c = 3; c <= 4; c++) begin
         checks++;
         if (outv !== exp) begin errors++; $display("FAIL excst_wait_c%0d: got %b exp %b", c, outv, exp); end
         tick();
      end
      i_stall = 0; #1;
      exp = {5'b00000, 4'b1000, 3'b001}; checks++;
      if (outv !== exp) begin errors++; $display("FAIL excst_drop: got %b exp %b", outv, exp); end
      tick();
      exp = 12'b0; checks++;
      if (outv !== exp) begin errors++; $display("FAIL excst_clear: got %b exp %b", outv, exp); end
      tick();
   endtask

   task automatic test_mispredict();
      mispredictM = 1; #1;
      exp = {5'b00000, 4'b1000, 3'b000}; checks++;
      if (outv !== exp) begin errors++; $display("FAIL mp_alone: got %b exp %b", outv, exp); end
      i_stall = 1; #1;
      exp = {5'b11111, 4'b0000, 3'b000}; checks++;
      if (outv !== exp) begin errors++; $display("FAIL mp_istall: got %b exp %b", outv, exp); end
      tick(); clr(); div_reqE = 1; tick();
      mispredictM = 1; #1;
      exp = {5'b00100, 4'b1010, 3'b000}; checks++;
      if (outv !== exp) begin errors++; $display("FAIL mp_div: got %b exp %b", outv, exp); end
      tick(); mispredictM = 0; div_readyE = 1; #1;
      exp = 12'b0; checks++;
      if (outv !== exp) begin errors++; $display("FAIL mp_div_done: got %b exp %b", outv, exp); end
      tick(); clr(); tick();
   endtask

   task automatic test_rst_div();
      div_reqE = 1; tick(); tick();
      rst = 1; exceptM = 1; #1;
      exp = 12'b0; checks++;
      if (outv !== exp) begin errors++; $display("FAIL rstdiv_out: got %b exp %b", outv, exp); end
      tick(); rst = 0; clr(); #1;
      checks++;
      if (dut.state_q !== 2'd0) begin errors++; $display("FAIL rstdiv_idle: got %0d exp 0", dut.state_q); end
      checks++;
      if (outv !== exp) begin errors++; $display("FAIL rstdiv_after: got %b exp %b", outv, exp); end
      tick();
   endtask

   initial begin
      clk = 0; rst = 1; clr();
      tick();
      test_reset();
      test_load_use();
      test_div_latency4();
      test_div_dstall();
      test_exc_div();
      test_exc_stall();
      test_mispredict();
      test_rst_div();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
